// File: rtl/input_port.sv
// -----------------------------------------------------------------------------
// input_port
//   Input-side counterpart of the processor output register. Samples WORD_W
//   asynchronous external lines (switches/buttons), brings them into the clk
//   domain through a two-flop synchroniser, debounces the whole word with one
//   shared counter, and presents the accepted word to the processor datapath.
//   New data is flagged by ready and a sticky per-bit change mask. The
//   processor acknowledges with a one-cycle RE read strobe.
//
// Ports
//   clk       in   1       system clock, all state updates on posedge
//   n_reset   in   1       asynchronous active-low reset
//   switches  in   WORD_W  raw external inputs, asynchronous to clk
//   RE        in   1       read strobe from the processor (one-cycle pulse)
//   Rdata     out  WORD_W  debounced stable word, straight from a register
//   ready     out  1       an accepted value exists that has not been read
//   changed   out  WORD_W  sticky mask of bits toggled since the last read
// -----------------------------------------------------------------------------
module input_port #(
    parameter int WORD_W          = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [WORD_W-1:0] switches,
    input  logic              RE,
    output logic [WORD_W-1:0] Rdata,
    output logic              ready,
    output logic [WORD_W-1:0] changed
);

    // Counter wide enough to hold DEBOUNCE_CYCLES, never narrower than 1 bit.
    localparam int CNT_W_RAW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WORD_W-1:0] sync1_q;
    logic [WORD_W-1:0] sync2_q;
    logic [WORD_W-1:0] cand_q;
    logic [WORD_W-1:0] cand_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [WORD_W-1:0] stable_q;
    logic [WORD_W-1:0] stable_d;
    logic              ready_q;
    logic              ready_d;
    logic [WORD_W-1:0] changed_q;
    logic [WORD_W-1:0] changed_d;
    logic              event_s;
    logic [WORD_W-1:0] diff_s;

    // Debounce decision: restart on any change, count while steady, accept on saturation.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        event_s  = 1'b0;
        diff_s   = {WORD_W{1'b0}};
        if (sync2_q != cand_q) begin
            // Any movement of the synchronised word restarts the whole count,
            // so an intermediate bounce value can never reach stable.
            cand_d = sync2_q;
            cnt_d  = {CNT_W{1'b0}};
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            // Saturated: counter holds, re-accepting the same value is a no-op.
            stable_d = cand_q;
            if (cand_q != stable_q) begin
                event_s = 1'b1;
                diff_s  = cand_q ^ stable_q;
            end else begin
                event_s = 1'b0;
                diff_s  = {WORD_W{1'b0}};
            end
        end
    end

    // Handshake flags: a new update beats a simultaneous read.
    always_comb begin
        if (event_s) begin
            ready_d = 1'b1;
        end else if (RE) begin
            ready_d = 1'b0;
        end else begin
            ready_d = ready_q;
        end
        changed_d = (RE ? {WORD_W{1'b0}} : changed_q) | diff_s;
    end

    // State registers: synchroniser, debounce state and processor-visible flags.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sync1_q   <= {WORD_W{1'b0}};
            sync2_q   <= {WORD_W{1'b0}};
            cand_q    <= {WORD_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            stable_q  <= {WORD_W{1'b0}};
            ready_q   <= 1'b0;
            changed_q <= {WORD_W{1'b0}};
        end else begin
            sync1_q   <= switches;
            sync2_q   <= sync1_q;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            ready_q   <= ready_d;
            changed_q <= changed_d;
        end
    end

    assign Rdata   = stable_q;
    assign ready   = ready_q;
    assign changed = changed_q;

endmodule

// File: tb/tb_input_port.sv
// -----------------------------------------------------------------------------
// tb_input_port
//   Directed scenarios with hand-computed expectations, followed by a long
//   randomized run (value changes, single-bit bounces, read strobes and
//   occasional mid-cycle resets). A run-length reference model predicts the
//   outputs; one compare process checks them on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_input_port;

    localparam int W  = 16;
    localparam int DC = 4;

    logic         clk;
    logic         n_reset;
    logic [W-1:0] switches;
    logic         RE;
    logic [W-1:0] Rdata;
    logic         ready;
    logic [W-1:0] changed;

    int n_checks;
    int n_fail;
    bit cmp_en;

    // Reference model state
    logic [W-1:0] m_rdata;
    logic         m_ready;
    logic [W-1:0] m_changed;
    logic [W-1:0] samp[$];   // raw samples of switches, one per rising edge
    logic [W-1:0] run_val;   // value of the current run of identical synchronised samples
    int           run_len;   // length of that run

    input_port #(.WORD_W(W), .DEBOUNCE_CYCLES(DC)) dut (
        .clk      (clk),
        .n_reset  (n_reset),
        .switches (switches),
        .RE       (RE),
        .Rdata    (Rdata),
        .ready    (ready),
        .changed  (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reset: nothing accepted, and the empty synchroniser counts as one sample of 0.
    task automatic model_reset();
        m_rdata   = '0;
        m_ready   = 1'b0;
        m_changed = '0;
        samp.delete();
        samp.push_back('0);
        samp.push_back('0);
        run_val = '0;
        run_len = 1;
    endtask

    // One rising edge: a value is accepted once the synchronised word has held
    // it for DC+1 consecutive edges (the capturing edge plus DC more).
    task automatic model_edge();
        logic [W-1:0] v;
        logic [W-1:0] diff;
        bit acc;
        bit ev;
        v = samp[samp.size() - 2];   // what the two-flop synchroniser shows now
        if (v == run_val) begin
            if (run_len < 1000) run_len++;
        end else begin
            run_val = v;
            run_len = 1;
        end
        acc  = (run_len >= DC + 1);
        ev   = acc && (v != m_rdata);
        diff = v ^ m_rdata;
        m_changed = (RE ? '0 : m_changed) | (ev ? diff : '0);
        if (ev) m_ready = 1'b1;
        else if (RE) m_ready = 1'b0;
        if (acc) m_rdata = v;
        samp.push_back(switches);
        if (samp.size() > 4) void'(samp.pop_front());
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) model_reset();
            else model_edge();
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("rdata_model", Rdata, m_rdata);
                chk("ready_model", {15'd0, ready}, {15'd0, m_ready});
                chk("changed_model", changed, m_changed);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_pulse();
        RE = 1'b1;
        cyc(1);
        RE = 1'b0;
    endtask

    task automatic async_reset_check();
        #2 n_reset = 1'b0;
        #1;
        chk("rst_rdata", Rdata, 16'h0000);
        chk("rst_ready", {15'd0, ready}, 16'h0000);
        chk("rst_changed", changed, 16'h0000);
        @(negedge clk);
        n_reset = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cmp_en   = 1'b0;
        n_reset  = 1'b1;
        switches = '0;
        RE       = 1'b0;
        #1 n_reset = 1'b0;
        cmp_en = 1'b1;
        cyc(3);
        n_reset = 1'b1;

        // Quiet inputs: nothing ever reported.
        cyc(50);
        chk("idle_rdata", Rdata, 16'h0000);
        chk("idle_ready", {15'd0, ready}, 16'h0000);
        chk("idle_changed", changed, 16'h0000);

        // Clean step 0 -> 00A5: visible exactly 6 edges after being sampled.
        switches = 16'h00A5;
        cyc(6);
        chk("step_early_rdata", Rdata, 16'h0000);
        cyc(1);
        chk("step_rdata", Rdata, 16'h00A5);
        chk("step_ready", {15'd0, ready}, 16'h0001);
        chk("step_changed", changed, 16'h00A5);
        read_pulse();
        chk("read_ready", {15'd0, ready}, 16'h0000);
        chk("read_changed", changed, 16'h0000);
        chk("read_rdata", Rdata, 16'h00A5);

        // Second update while 00A5 is still unread: masks accumulate.
        switches = 16'h00A5;
        cyc(3);
        switches = 16'h0000;
        cyc(10);
        read_pulse();
        switches = 16'h00A5;
        cyc(10);
        switches = 16'h00F0;
        cyc(7);
        chk("accum_rdata", Rdata, 16'h00F0);
        chk("accum_ready", {15'd0, ready}, 16'h0001);
        chk("accum_changed", changed, 16'h00F5);

        // Read strobe on the very edge of the 00A5 -> 00F0 update.
        read_pulse();
        switches = 16'h00A5;
        cyc(10);
        read_pulse();
        switches = 16'h00F0;
        cyc(6);
        read_pulse();
        chk("coll_ready", {15'd0, ready}, 16'h0001);
        chk("coll_changed", changed, 16'h0055);
        chk("coll_rdata", Rdata, 16'h00F0);
        read_pulse();

        // Short glitches are rejected; the shortest accepted pulse spans DC+1 edges.
        switches = 16'h0000;
        cyc(10);
        read_pulse();
        switches = 16'h0001;
        cyc(3);
        switches = 16'h0000;
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            chk("glitch3_rdata", Rdata, 16'h0000);
            chk("glitch3_ready", {15'd0, ready}, 16'h0000);
        end
        switches = 16'h0001;
        cyc(4);
        switches = 16'h0000;
        cyc(10);
        switches = 16'h0001;
        cyc(5);
        switches = 16'h0000;
        cyc(2);
        chk("pulse5_rdata", Rdata, 16'h0001);
        chk("pulse5_ready", {15'd0, ready}, 16'h0001);
        chk("pulse5_changed", changed, 16'h0001);
        cyc(10);
        read_pulse();

        // Reset in the middle of a count with FFFF held, then a fresh accept.
        switches = 16'hFFFF;
        cyc(3);
        async_reset_check();
        cyc(6);
        chk("pwr_early_rdata", Rdata, 16'h0000);
        cyc(1);
        chk("pwr_rdata", Rdata, 16'hFFFF);
        chk("pwr_ready", {15'd0, ready}, 16'h0001);
        chk("pwr_changed", changed, 16'hFFFF);

        // Randomized traffic: new words, single-bit bounces, reads, rare resets.
        for (int i = 0; i < 4000; i++) begin
            int r;
            cyc(1);
            r = $urandom_range(0, 99);
            if (r < 8) switches = W'($urandom);
            else if (r < 15) switches = switches ^ (16'h0001 << $urandom_range(0, 15));
            RE = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 599) == 0) async_reset_check();
        end
        RE = 1'b0;
        cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
